// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants and types for the unified memory port arbiter
// Contents:
//   WORD_LEN   - datapath / address width
//   arb_own_e  - response owner encoding (ARB_OWN_NONE / ARB_OWN_I / ARB_OWN_D)
package mem_port_arbiter_pkg;

    localparam int WORD_LEN = 32;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_OWN_NONE = 2'd0,
        ARB_OWN_I    = 2'd1,
        ARB_OWN_D    = 2'd2
    } arb_own_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between fetch (I) and load/store (D)
// Ports:
//   i_req, d_req   in   requests from fetch and load/store stages
//   rr_last_i      in   (ARB_ROUND_ROBIN_EN only) 1 = I won the last contended cycle
//   starve_hit     in   (default build) I has been denied STARVE_LIMIT cycles in a row
//   pick_i, pick_d out  one-hot (or zero) winner
// Configuration macro: ARB_ROUND_ROBIN_EN (alternate winners on contention instead of
//   D-priority with starvation override).
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic rr_last_i,
`else
    input  logic starve_hit,
`endif
    output logic pick_i,
    output logic pick_d
);

    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Contended: hand the port to whoever did not win last time.
            if (rr_last_i) begin
                pick_d = 1'b1;
            end else begin
                pick_i = 1'b1;
            end
`else
            // Contended: D normally wins so the pipeline back end drains first,
            // but a starved fetch is forced through.
            if (starve_hit) begin
                pick_i = 1'b1;
            end else begin
                pick_d = 1'b1;
            end
`endif
        end else begin
            pick_i = i_req;
            pick_d = d_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one registered-read memory port between fetch and load/store
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr/i_gnt            fetch request, byte address, grant (combinational)
//   i_rvalid/i_rdata              fetch response, cycle after i_gnt
//   d_req/d_addr/d_wen/d_wdata    data request (d_wen=1 store), grant d_gnt (combinational)
//   d_rvalid/d_rdata              load response, cycle after a granted load
//   m_addr/m_wen/m_wdata/m_rdata  memory port; m_rdata valid one cycle after m_addr
// Parameter: STARVE_LIMIT (1..15) cycles I may lose to D before I is forced to win.
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin on contention; no starvation counter).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic [WORD_LEN-1:0] m_addr,
    output logic                m_wen,
    output logic [WORD_LEN-1:0] m_wdata,
    input  logic [WORD_LEN-1:0] m_rdata
);

    logic     pick_i;
    logic     pick_d;
    arb_own_e owner;
    arb_own_e owner_nxt;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = I won the most recent contended cycle; reset value points at D so I goes first.
    logic rr_last_i;

    mem_arb_pick u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .rr_last_i (rr_last_i),
        .pick_i    (pick_i),
        .pick_d    (pick_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_i <= 1'b0;
        end else if (i_req && d_req) begin
            rr_last_i <= i_gnt;
        end
    end
`else
    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;

    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_hit (starve_hit),
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

    // Counts consecutive cycles I was waiting while D took the port; any gap in
    // the fetch request or a fetch grant restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    // Grants are held off during reset so nothing reaches memory.
    assign i_gnt   = pick_i & ~rst;
    assign d_gnt   = pick_d & ~rst;

    assign m_addr  = d_gnt ? d_addr : i_addr;
    assign m_wen   = d_gnt & d_wen;
    assign m_wdata = d_wdata;

    always_comb begin
        owner_nxt = ARB_OWN_NONE;
        if (i_gnt) begin
            owner_nxt = ARB_OWN_I;
        end else if (d_gnt && !d_wen) begin
            owner_nxt = ARB_OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= ARB_OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // A response already in flight when reset hits is dropped in the reset cycle too.
    assign i_rvalid = (owner == ARB_OWN_I) & ~rst;
    assign d_rvalid = (owner == ARB_OWN_D) & ~rst;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_wen;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Memory model: registered read, read-first, unwritten words hold a known pattern.
    logic [31:0]  mem [0:255];
    logic [255:0] mem_vld;
    logic         tb_init;

    function automatic logic [31:0] w(input int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    always @(posedge clk) begin
        if (tb_init) begin
            mem_vld <= '0;
        end else if (m_wen) begin
            mem[m_addr[9:2]]     <= m_wdata;
            mem_vld[m_addr[9:2]] <= 1'b1;
        end
        m_rdata <= mem_vld[m_addr[9:2]] ? mem[m_addr[9:2]] : w(int'(m_addr[9:2]));
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da, input logic dw,
                         input logic [31:0] wd);
        rst = r; i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wen = dw; d_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        d_wen;
        logic [31:0] d_wdata;
        logic        e_ig;
        logic        e_dg;
        logic        e_mwen;
        logic [31:0] e_maddr;
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic [31:0] da, input logic dw,
                                input logic [31:0] wd, input logic eig, input logic edg,
                                input logic emw, input logic [31:0] ema, input logic eirv,
                                input logic edrv, input logic [31:0] erd);
        vec_t v;
        v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_addr = da;
        v.d_wen = dw; v.d_wdata = wd; v.e_ig = eig; v.e_dg = edg; v.e_mwen = emw;
        v.e_maddr = ema; v.e_irv = eirv; v.e_drv = edrv; v.e_rdata = erd;
        return v;
    endfunction

    vec_t tbl[17];
    int   prev;
    logic win_i;

    initial begin
        //            rst ir ia      dr da       dw wd            ig dg mw maddr   irv drv rdata
        tbl[0]  = mk(1, 1, 32'h0,  1, 32'h10,  1, 32'h0,        0, 0, 0, 32'h0,   0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h20, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h20,  0, 0, 32'h0);
        tbl[2]  = mk(0, 1, 32'h0,  0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h0,   0, 0, 32'h0);
        tbl[3]  = mk(0, 1, 32'h4,  0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h4,   1, 0, w(0));
        tbl[4]  = mk(0, 1, 32'h8,  0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h8,   1, 0, w(1));
        tbl[5]  = mk(0, 0, 32'h8,  0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h8,   1, 0, w(2));
        tbl[6]  = mk(0, 0, 32'h8,  0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h8,   0, 0, 32'h0);
        tbl[7]  = mk(0, 0, 32'h8,  1, 32'h100, 1, 32'hDEADBEEF, 0, 1, 1, 32'h100, 0, 0, 32'h0);
        tbl[8]  = mk(0, 0, 32'h8,  1, 32'h100, 0, 32'hDEADBEEF, 0, 1, 0, 32'h100, 0, 0, 32'h0);
        tbl[9]  = mk(0, 0, 32'h8,  0, 32'h100, 0, 32'h0,        0, 0, 0, 32'h8,   0, 1, 32'hDEADBEEF);
        tbl[10] = mk(0, 1, 32'hC,  0, 32'h0,   0, 32'h0,        1, 0, 0, 32'hC,   0, 0, 32'h0);
        tbl[11] = mk(0, 0, 32'hC,  1, 32'h14,  0, 32'h0,        0, 1, 0, 32'h14,  1, 0, w(3));
        tbl[12] = mk(0, 0, 32'hC,  0, 32'h14,  0, 32'h0,        0, 0, 0, 32'hC,   0, 1, w(5));
        tbl[13] = mk(0, 0, 32'hC,  0, 32'h0,   0, 32'h0,        0, 0, 0, 32'hC,   0, 0, 32'h0);
        tbl[14] = mk(0, 0, 32'hC,  1, 32'h200, 1, 32'h12345678, 0, 1, 1, 32'h200, 0, 0, 32'h0);
        tbl[15] = mk(0, 1, 32'h18, 0, 32'h200, 0, 32'h0,        1, 0, 0, 32'h18,  0, 0, 32'h0);
        tbl[16] = mk(0, 0, 32'h18, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h18,  1, 0, w(6));

        tb_init = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tb_init = 1'b0;

        for (int n = 0; n < 17; n++) begin
            drive(tbl[n].rst, tbl[n].i_req, tbl[n].i_addr, tbl[n].d_req, tbl[n].d_addr,
                  tbl[n].d_wen, tbl[n].d_wdata);
            @(negedge clk);
            chk1("tbl_i_gnt", i_gnt, tbl[n].e_ig);
            chk1("tbl_d_gnt", d_gnt, tbl[n].e_dg);
            chk1("tbl_m_wen", m_wen, tbl[n].e_mwen);
            chk32("tbl_m_addr", m_addr, tbl[n].e_maddr);
            chk32("tbl_m_wdata", m_wdata, tbl[n].d_wdata);
            chk1("tbl_i_rvalid", i_rvalid, tbl[n].e_irv);
            chk1("tbl_d_rvalid", d_rvalid, tbl[n].e_drv);
            if (tbl[n].e_irv) chk32("tbl_i_rdata", i_rdata, tbl[n].e_rdata);
            if (tbl[n].e_drv) chk32("tbl_d_rdata", d_rdata, tbl[n].e_rdata);
            tick();
        end

        // Sustained contention, loads only: I @0x40 (word 16), D @0x80 (word 32).
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 32'h40, 1, 32'h80, 0, 0);
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            win_i = (k % 2) == 0;
`else
            win_i = (k % (LIM + 1)) == LIM;
`endif
            chk1("cont_i_gnt", i_gnt, win_i);
            chk1("cont_d_gnt", d_gnt, !win_i);
            chk1("cont_i_rvalid", i_rvalid, prev == 1);
            chk1("cont_d_rvalid", d_rvalid, prev == 2);
            if (prev == 1) chk32("cont_i_rdata", i_rdata, w(16));
            if (prev == 2) chk32("cont_d_rdata", d_rdata, w(32));
            prev = win_i ? 1 : 2;
            tick();
        end

        // I drops its request while being starved: counter must clear.
        drive(0, 0, 32'h40, 1, 32'h80, 0, 0);
        @(negedge clk);
        chk1("drop_d_gnt", d_gnt, 1'b1);
        chk1("drop_i_gnt", i_gnt, 1'b0);
        chk1("drop_d_rvalid", d_rvalid, 1'b1);
`ifndef ARB_ROUND_ROBIN_EN
        chk32("drop_starve_before", {28'b0, dut.starve_cnt}, 32'd3);
`endif
        tick();
        drive(0, 1, 32'h40, 1, 32'h80, 0, 0);
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        chk1("after_drop_i_gnt", i_gnt, 1'b1);
`else
        chk32("drop_starve_after", {28'b0, dut.starve_cnt}, 32'd0);
        chk1("after_drop_d_gnt", d_gnt, 1'b1);
`endif
        chk1("after_drop_d_rvalid", d_rvalid, 1'b1);
        chk32("after_drop_d_rdata", d_rdata, w(32));
        tick();

        // Reset with a fetch response in flight.
        drive(0, 1, 32'h24, 0, 32'h0, 0, 0);
        @(negedge clk);
        chk1("rstf_n_i_gnt", i_gnt, 1'b1);
        tick();
        drive(1, 1, 32'h24, 1, 32'h300, 1, 32'h55AA55AA);
        @(negedge clk);
        chk1("rstf_n1_i_gnt", i_gnt, 1'b0);
        chk1("rstf_n1_d_gnt", d_gnt, 1'b0);
        chk1("rstf_n1_m_wen", m_wen, 1'b0);
        chk1("rstf_n1_i_rvalid", i_rvalid, 1'b0);
        chk1("rstf_n1_d_rvalid", d_rvalid, 1'b0);
        tick();
        drive(0, 1, 32'h28, 0, 32'h0, 0, 0);
        @(negedge clk);
        chk1("rstf_n2_i_rvalid", i_rvalid, 1'b0);
        chk1("rstf_n2_d_rvalid", d_rvalid, 1'b0);
        chk1("rstf_n2_i_gnt", i_gnt, 1'b1);
`ifndef ARB_ROUND_ROBIN_EN
        chk32("rstf_n2_starve", {28'b0, dut.starve_cnt}, 32'd0);
`endif
        tick();
        drive(0, 1, 32'h2C, 1, 32'h30, 0, 0);
        @(negedge clk);
        chk1("rstf_n3_i_rvalid", i_rvalid, 1'b1);
        chk32("rstf_n3_i_rdata", i_rdata, w(10));
`ifdef ARB_ROUND_ROBIN_EN
        chk1("rstf_n3_i_gnt", i_gnt, 1'b1);
`else
        chk1("rstf_n3_d_gnt", d_gnt, 1'b1);
`endif
        tick();
        drive(0, 0, 32'h2C, 0, 32'h0, 0, 0);
        @(negedge clk);
        chk1("idle_i_gnt", i_gnt, 1'b0);
        chk1("idle_d_gnt", d_gnt, 1'b0);
        chk1("idle_m_wen", m_wen, 1'b0);
        tick();
        @(negedge clk);
        chk1("idle_i_rvalid", i_rvalid, 1'b0);
        chk1("idle_d_rvalid", d_rvalid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
